// File: rtl/dmg_bus_pkg.sv
// dmg_bus_pkg: shared FSM states, address map and command bundle
// for the DMG internal register bus master.
package dmg_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_T4
  } state_e;

  localparam logic [15:0] ADDR_FF04   = 16'hFF04;
  localparam logic [15:0] ADDR_FF26   = 16'hFF26;
  localparam logic [15:0] ADDR_FF60   = 16'hFF60;
  localparam logic [15:0] ADDR_APU_LO = 16'hFF10;
  localparam logic [15:0] ADDR_APU_HI = 16'hFF3F;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  // Undriven or unknown bus bits read as 1, like the board pull-ups.
  function automatic logic [7:0] open_bus(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = (v[i] !== 1'b0);
    end
    return r;
  endfunction

endpackage

// File: rtl/dmg_bus_cmd_fifo.sv
// dmg_bus_cmd_fifo: small command queue in front of the bus FSM,
// only instantiated when DMG_BUS_CMD_FIFO_EN is defined.
module dmg_bus_cmd_fifo
  import dmg_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CAP);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d = (wr_q == LAST) ? '0 : wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
    end
    cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmg_bus_master.sv
// dmg_bus_master: CPU-side 4-T-state initiator for the DMG register bus.
// Define DMG_BUS_CMD_FIFO_EN to queue commands in dmg_bus_cmd_fifo.
module dmg_bus_master
  import dmg_bus_pkg::*;
#(
  parameter logic [15:0] APU_LO     = ADDR_APU_LO,
  parameter logic [15:0] APU_HI     = ADDR_APU_HI,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        ack,
  output logic [7:0]  rdata,
  inout  wire  [7:0]  d,
  output logic        cpu_rd,
  output logic        cpu_wr,
  output logic        apu_wr,
  output logic        ff04_ff07,
  output logic        ff26,
  output logic        ff60_d1,
  output logic        tola_na1,
  output logic        tovy_na0
);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  cmd_t       in_cmd, start_cmd;
  logic [7:0] rdata_q, rdata_d;
  logic       start, busy, in_apu, d_oe, slot;

  assign in_cmd = {we, addr, wdata};
  assign slot   = (state_q == S_IDLE) || (state_q == S_T4);

`ifdef DMG_BUS_CMD_FIFO_EN
  logic fifo_full, fifo_empty;

  dmg_bus_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (req && !fifo_full),
    .din   (in_cmd),
    .pop   (start),
    .dout  (start_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_full;
  assign start = slot && !fifo_empty;
`else
  logic unused_cfg;

  assign unused_cfg = ^FIFO_DEPTH;
  assign ready      = slot;
  assign start      = req && slot;
  assign start_cmd  = in_cmd;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_T1;
      cmd_d   = start_cmd;
    end
    if (state_q == S_T3 && !cmd_q.we) begin
      rdata_d = open_bus(d);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rdata_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  // All strobes and decodes come from flops only, never from req.
  assign busy   = (state_q != S_IDLE);
  assign in_apu = (cmd_q.addr >= APU_LO) && (cmd_q.addr <= APU_HI);
  assign d_oe   = cmd_q.we &&
                  (state_q == S_T2 || state_q == S_T3);
  assign d      = d_oe ? cmd_q.wdata : 8'hzz;

  assign cpu_rd    = !cmd_q.we &&
                     (state_q == S_T2 || state_q == S_T3);
  assign cpu_wr    = cmd_q.we && (state_q == S_T3);
  assign apu_wr    = cpu_wr && in_apu;
  assign ff04_ff07 = busy &&
                     (cmd_q.addr[15:2] == ADDR_FF04[15:2]);
  assign ff26      = busy && (cmd_q.addr == ADDR_FF26);
  assign ff60_d1   = busy && (cmd_q.addr == ADDR_FF60);
  assign tola_na1  = !busy || !cmd_q.addr[1];
  assign tovy_na0  = !busy || !cmd_q.addr[0];
  assign ack       = (state_q == S_T4);
  assign rdata     = rdata_q;

endmodule

// File: doc/dmg_bus_master.md
# dmg_bus_master

CPU-side initiator for the internal DMG register bus. Turns a simple request/acknowledge command interface into 4-T-state machine cycles that drive the strobes and decodes consumed by the clock/divider and APU-control blocks: `cpu_rd`, `cpu_wr`, `apu_wr`, `ff04_ff07`, `tola_na1`, `tovy_na0`, `ff26`, `ff60_d1` and the shared `d` bus. It stands in for the CPU in the simulation top level and later sits between the CPU core model and the register blocks.

## Interface
Parameters:
- `APU_LO`, default 16'hFF10, lowest address decoded as APU space.
- `APU_HI`, default 16'hFF3F, highest address decoded as APU space.
- `FIFO_DEPTH`, default 2, command FIFO depth; used only with `DMG_BUS_CMD_FIFO_EN`.

Ports:
- `clk`  in  1  T-state clock (4 MHz); all state changes on rising edge.
- `nreset`  in  1  reset, asynchronous, active-low.
- `req`  in  1  command valid.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  16  command address.
- `wdata`  in  8  write data.
- `ready`  out  1  command accepted this edge if `req`.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  8  read result; valid while `ack`, held until the next read completes.
- `d`  inout  8  shared data bus.
- `cpu_rd`, `cpu_wr`, `apu_wr`  out  1  bus strobes.
- `ff04_ff07`, `ff26`, `ff60_d1`  out  1  address decodes.
- `tola_na1`, `tovy_na0`  out  1  `!addr[1]`, `!addr[0]` of the latched address.

## Operation
- FSM states: IDLE, T1, T2, T3, T4. Command accepted on an edge where `req && ready`. Command is latched into `cmd_we`, `cmd_addr`, `cmd_wdata`; next state is T1.
- Sequence T1→T2→T3→T4 is unconditional. From T4: go to T1 if a command is accepted on that edge, else go to IDLE.
- `ready` = IDLE or T4.
- Decodes come from the latched address and are high in T1–T4 only, never in IDLE:
  - `ff04_ff07` = `addr[15:2]` == FF04>>2.
  - `ff26` = `addr` == FF26.
  - `ff60_d1` = `addr` == FF60.
  - `tola_na1`/`tovy_na0` are 1 in IDLE.
- Read:
  - `cpu_rd` high in T2 and T3.
  - `d` is sampled on the T3→T4 edge. Any bit that is z or x reads as 1 (open-bus pull-up).
  - The sampled value is loaded into `rdata`.
- Write:
  - `d` is driven with `cmd_wdata` in T2 and T3, and is z in every other state.
  - `cpu_wr` is high in T3 only.
  - `apu_wr` is high in T3 only, when `APU_LO` ≤ addr ≤ `APU_HI`.
- `ack` is high for exactly the T4 cycle, for both reads and writes.
- Reset values: state IDLE, all strobes 0, decodes 0, `tola_na1`/`tovy_na0` = 1, `ack` 0, `ready` 1, `rdata` 8'hFF, `d` released (z).
- Reset mid-transaction aborts immediately. No `ack` is issued, strobes drop asynchronously, and the aborted command is discarded.

## Timing
- Accept edge = edge 0. T1 runs during cycle 1. Strobes follow the state register only, so there is no combinational path from `req`.
- Latency: `ack` is asserted in cycle 4 after the accept edge.
- Back-to-back throughput: one command per 4 cycles, with no IDLE gap when `req` is held.
- `req` deasserted while `ready` = 0 has no effect. A command is never partially accepted.
- Outputs may change only on `clk` rising edges or on `nreset` falling. `d` is not driven in T1, so the bus turns around for one T-state between a read and the next write.

## Configuration
- `DMG_BUS_CMD_FIFO_EN` defined:
  - Accepted commands enter a `FIFO_DEPTH`-entry FIFO.
  - `ready` = FIFO not full, independent of FSM state.
  - The FSM pops a command in IDLE or T4 when the FIFO is non-empty.
  - Push and pop on the same edge when full is allowed.
  - `ack`s are issued in acceptance order.
  - Reset flushes the FIFO.
- Not defined: no FIFO; the `ready` rule above applies.

## Structure
- Package `dmg_bus_pkg` holds:
  - the FSM state enum;
  - address constants `ADDR_FF04`, `ADDR_FF26`, `ADDR_FF60`, `ADDR_APU_LO`, `ADDR_APU_HI`;
  - the command struct {we, addr, wdata}.
- Sub-module `dmg_bus_cmd_fifo` exists only under the macro: synchronous push/pop, async active-low reset, `full`/`empty` flags.

## Test plan
- Write FF04 with wdata 8'h5A:
  - T3 shows `cpu_wr`=1, `ff04_ff07`=1, `tola_na1`=1, `tovy_na0`=1, `apu_wr`=0.
  - `d`=5A in T2–T3.
  - `ack` in cycle 4.
- Read FF26 with `d[7]` driven 0 by the responder and other bits z:
  - `cpu_rd` in T2–T3.
  - `rdata`=8'h7F with `ack` in cycle 4.
- Write FF24 with 8'h77, then immediately read FF05:
  - `apu_wr`=1 in the first T3 only.
  - Second command starts in T1 with no IDLE gap.
  - `ff04_ff07`=1 and `tovy_na0`=0 during the read.
  - Two `ack`s spaced 4 cycles apart.
- Deassert `nreset` during T2 of a write:
  - `d` goes to z and `cpu_wr` stays 0.
  - No `ack`.
  - After release, `ready`=1 and `rdata`=8'hFF.
- With `DMG_BUS_CMD_FIFO_EN`, push 3 reads in 3 consecutive cycles:
  - `ready` drops after 2 queued commands.
  - 3 `ack`s arrive in order, with `rdata` matching each address's responder value.
- Read of unmapped FFFF with `d` all z → `rdata`=8'hFF, all decodes 0 throughout.
